// File: rtl/otter_cu_pkg.sv
// Shared types and encodings for the OTTER multicycle control unit.
package otter_cu_pkg;

    // Control FSM phases
    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        LD_WAIT = 3'd3,
        ST_WAIT = 3'd4,
        INTR    = 3'd5
    } cu_state_t;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    // SYSTEM sub-decodes (IR[14:12])
    localparam logic [2:0] F3_MRET  = 3'b000;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    // Opcodes that write rd and advance the PC in a single EXEC cycle
    localparam int N_ALU_OPS = 6;
    localparam logic [6:0] ALU_OPS [N_ALU_OPS] = '{
        OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
    };

    // Wait-state counter width; covers the full 1..255 timeout range
    localparam int WAIT_CNT_W = 8;

    // States in which the memory may stall us and the timeout applies
    function automatic logic is_wait_state(input cu_state_t s);
        return (s == FETCH) || (s == LD_WAIT) || (s == ST_WAIT);
    endfunction

endpackage

// File: rtl/otter_wait_timer.sv
// Counts consecutive stalled cycles and flags when the stall budget is used up.
module otter_wait_timer
    import otter_cu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    // The MAX_WAIT-th stalled cycle is the one that sees count == MAX_WAIT-1
    localparam logic [WAIT_CNT_W-1:0] LIMIT = WAIT_CNT_W'(MAX_WAIT - 1);

    logic [WAIT_CNT_W-1:0] count_reg;
    logic [WAIT_CNT_W-1:0] count_next;

    // Next count: clear wins over increment so a finished phase restarts at zero
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = count_reg + WAIT_CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    // Expiry only while actually stalled, so a late ready never counts as a timeout
    assign expired = en && (count_reg == LIMIT);

endmodule

// File: rtl/otter_cu_fsm.sv
// Multicycle control FSM for the OTTER MCU: fetch, execute, memory waits,
// interrupt entry and MRET, with a bounded memory stall.
module otter_cu_fsm
    import otter_cu_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INTR,
    input  logic       MIE,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       MEM_RDY,
    output logic       RESET_OUT,
    output logic       IR_WE,
    output logic       PC_WE,
    output logic       RF_WE,
    output logic       MEM_RDEN1,
    output logic       MEM_RDEN2,
    output logic       MEM_WE2,
    output logic       CSR_WE,
    output logic       INT_TAKEN,
    output logic       MRET_EXEC,
    output logic       ILLEGAL,
    output logic       BUS_ERR
);

    // The INTR port shadows the package state literal of the same name,
    // so the interrupt state is always referenced through the package scope.
    localparam cu_state_t ST_INTR = otter_cu_pkg::INTR;

    cu_state_t state_reg;
    cu_state_t state_next;
    logic      bus_err_reg;
    logic      bus_err_next;

    logic      instr_end;
    logic      timer_en;
    logic      timer_clr;
    logic      timer_expired;

    logic [N_ALU_OPS-1:0] alu_hit;
    logic                 is_alu;

    // One comparator per single-cycle ALU-class opcode
    genvar gi;
    generate
        for (gi = 0; gi < N_ALU_OPS; gi++) begin : g_alu_dec
            assign alu_hit[gi] = (OPCODE == ALU_OPS[gi]);
        end
    endgenerate

    assign is_alu = |alu_hit;

    // Stall budget shared by FETCH, LD_WAIT and ST_WAIT; it restarts whenever
    // the phase finishes, including a FETCH timeout that re-enters FETCH.
    assign timer_en  = is_wait_state(state_reg) && !MEM_RDY;
    assign timer_clr = (state_next != state_reg) || timer_expired;

    otter_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (CLK),
        .rst     (RST),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // State and sticky bus-error registers; reset drops straight back to INIT
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= INIT;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bus_err_reg <= bus_err_next;
        end
    end

    // Next-state and strobe decode; every strobe defaults low
    always_comb begin
        state_next   = state_reg;
        bus_err_next = bus_err_reg;
        instr_end    = 1'b0;
        RESET_OUT    = 1'b0;
        IR_WE        = 1'b0;
        PC_WE        = 1'b0;
        RF_WE        = 1'b0;
        MEM_RDEN1    = 1'b0;
        MEM_RDEN2    = 1'b0;
        MEM_WE2      = 1'b0;
        CSR_WE       = 1'b0;
        INT_TAKEN    = 1'b0;
        MRET_EXEC    = 1'b0;
        ILLEGAL      = 1'b0;

        case (state_reg)
            INIT: begin
                RESET_OUT  = 1'b1;
                state_next = FETCH;
            end

            FETCH: begin
                MEM_RDEN1 = 1'b1;
                if (MEM_RDY) begin
                    IR_WE      = 1'b1;
                    state_next = EXEC;
                end else if (timer_expired) begin
                    // Give up on this word: step the PC past it and refetch
                    PC_WE        = 1'b1;
                    bus_err_next = 1'b1;
                    state_next   = FETCH;
                end
            end

            EXEC: begin
                if (OPCODE == OP_LOAD) begin
                    MEM_RDEN2  = 1'b1;
                    state_next = LD_WAIT;
                end else if (OPCODE == OP_STORE) begin
                    MEM_WE2    = 1'b1;
                    state_next = ST_WAIT;
                end else if (is_alu) begin
                    RF_WE     = 1'b1;
                    PC_WE     = 1'b1;
                    instr_end = 1'b1;
                end else if (OPCODE == OP_BRANCH) begin
                    PC_WE     = 1'b1;
                    instr_end = 1'b1;
                end else if ((OPCODE == OP_SYS) && (FUNCT3 == F3_MRET)) begin
                    // MRET returns to FETCH; a pending interrupt waits one instruction
                    MRET_EXEC  = 1'b1;
                    PC_WE      = 1'b1;
                    state_next = FETCH;
                end else if ((OPCODE == OP_SYS) && (FUNCT3 == F3_CSRRW)) begin
                    CSR_WE    = 1'b1;
                    RF_WE     = 1'b1;
                    PC_WE     = 1'b1;
                    instr_end = 1'b1;
                end else begin
                    // Unknown encodings retire as a NOP with a one-cycle flag
                    ILLEGAL   = 1'b1;
                    PC_WE     = 1'b1;
                    instr_end = 1'b1;
                end
            end

            LD_WAIT: begin
                MEM_RDEN2 = 1'b1;
                if (MEM_RDY) begin
                    RF_WE     = 1'b1;
                    PC_WE     = 1'b1;
                    instr_end = 1'b1;
                end else if (timer_expired) begin
                    // No valid data arrived, so rd is left untouched
                    PC_WE        = 1'b1;
                    bus_err_next = 1'b1;
                    instr_end    = 1'b1;
                end
            end

            ST_WAIT: begin
                MEM_WE2 = 1'b1;
                if (MEM_RDY) begin
                    PC_WE     = 1'b1;
                    instr_end = 1'b1;
                end else if (timer_expired) begin
                    PC_WE        = 1'b1;
                    bus_err_next = 1'b1;
                    instr_end    = 1'b1;
                end
            end

            ST_INTR: begin
                INT_TAKEN  = 1'b1;
                PC_WE      = 1'b1;
                state_next = FETCH;
            end

            default: begin
                state_next = INIT;
            end
        endcase

        // Interrupts are only sampled on a retiring instruction's last cycle
        if (instr_end) begin
            state_next = (INTR && MIE) ? ST_INTR : FETCH;
        end
    end

    assign BUS_ERR = bus_err_reg;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: decode table, corner-case sequences
// and randomized instruction streams against a per-instruction phase model.
module tb_otter_cu_fsm;

    localparam int MAXW = 15;

    // Output vector bit masks {RESET_OUT .. ILLEGAL}
    localparam logic [10:0] RSTO = 11'h400;
    localparam logic [10:0] IRWE = 11'h200;
    localparam logic [10:0] PCWE = 11'h100;
    localparam logic [10:0] RFWE = 11'h080;
    localparam logic [10:0] RD1  = 11'h040;
    localparam logic [10:0] RD2  = 11'h020;
    localparam logic [10:0] WE2  = 11'h010;
    localparam logic [10:0] CSRW = 11'h008;
    localparam logic [10:0] INTT = 11'h004;
    localparam logic [10:0] MRT  = 11'h002;
    localparam logic [10:0] ILL  = 11'h001;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] SYS    = 7'b1110011;
    localparam logic [6:0] ADDI   = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst;
    logic       intr;
    logic       mie;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_rdy;
    logic       reset_out, ir_we, pc_we, rf_we, mem_rden1, mem_rden2;
    logic       mem_we2, csr_we, int_taken, mret_exec, illegal, bus_err;

    logic [10:0] outs;
    assign outs = {reset_out, ir_we, pc_we, rf_we, mem_rden1, mem_rden2,
                   mem_we2, csr_we, int_taken, mret_exec, illegal};

    int   n_tests = 0;
    int   n_fail  = 0;
    logic bus_flag = 1'b0;

    always #5 clk = ~clk;

    otter_cu_fsm #(.MAX_WAIT(MAXW)) dut (
        .CLK(clk), .RST(rst), .INTR(intr), .MIE(mie), .OPCODE(opcode),
        .FUNCT3(funct3), .MEM_RDY(mem_rdy), .RESET_OUT(reset_out),
        .IR_WE(ir_we), .PC_WE(pc_we), .RF_WE(rf_we), .MEM_RDEN1(mem_rden1),
        .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .CSR_WE(csr_we),
        .INT_TAKEN(int_taken), .MRET_EXEC(mret_exec), .ILLEGAL(illegal),
        .BUS_ERR(bus_err)
    );

    task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // One clock cycle: drive ready, check strobes and bus error, advance
    task automatic cyc(input logic rdy, input logic [10:0] exp, input string name);
        mem_rdy = rdy;
        #2;
        check(name, outs, exp);
        check({name, "_buserr"}, {10'd0, bus_err}, {10'd0, bus_flag});
        $display("[TB] t=%0t %s rdy=%b outs=%b bus_err=%b", $time, name, rdy, outs, bus_err);
        @(posedge clk);
        #1;
    endtask

    // Instruction classes from the decode rules
    typedef enum int {K_LOAD, K_STORE, K_ALU, K_BR, K_MRET, K_CSR, K_ILL} kind_t;

    function automatic kind_t kind_of(input logic [6:0] op, input logic [2:0] f3);
        case (op)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return K_ALU;
            7'b1100011: return K_BR;
            7'b1110011: return (f3 == 3'b000) ? K_MRET : (f3 == 3'b001) ? K_CSR : K_ILL;
            default:    return K_ILL;
        endcase
    endfunction

    // Memory phase: ready after 'dw' stalled cycles, or timeout on the MAXW-th stall
    task automatic mem_phase(input logic [10:0] strobe, input logic [10:0] done_ok,
                             input logic [10:0] done_to, input int dw, input string name);
        for (int j = 0; j < MAXW; j++) begin
            if (j == dw) begin
                cyc(1'b1, strobe | done_ok, {name, "_rdy"});
                return;
            end
            if (j == MAXW - 1) begin
                cyc(1'b0, strobe | done_to, {name, "_timeout"});
                bus_flag = 1'b1;
                return;
            end
            cyc(1'b0, strobe, {name, "_stall"});
        end
    endtask

    // Reference model for one instruction, phase by phase
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3, input int fw,
                            input int dw, input logic intr_v, input logic mie_v,
                            input logic exec_rdy, input string name);
        kind_t k;
        logic  retires;
        opcode = op;
        funct3 = f3;
        intr   = intr_v;
        mie    = mie_v;
        k      = kind_of(op, f3);
        for (int i = 0; i < MAXW; i++) begin
            if (i == fw) begin
                cyc(1'b1, RD1 | IRWE, {name, "_fetch"});
                break;
            end
            if (i == MAXW - 1) begin
                cyc(1'b0, RD1 | PCWE, {name, "_fetch_timeout"});
                bus_flag = 1'b1;
                return;
            end
            cyc(1'b0, RD1, {name, "_fetch_stall"});
        end
        retires = 1'b1;
        case (k)
            K_ALU:  cyc(exec_rdy, PCWE | RFWE, {name, "_exec"});
            K_BR:   cyc(exec_rdy, PCWE, {name, "_exec"});
            K_CSR:  cyc(exec_rdy, PCWE | RFWE | CSRW, {name, "_exec"});
            K_ILL:  cyc(exec_rdy, PCWE | ILL, {name, "_exec"});
            K_MRET: begin
                cyc(exec_rdy, PCWE | MRT, {name, "_exec"});
                retires = 1'b0;
            end
            K_LOAD: begin
                cyc(exec_rdy, RD2, {name, "_exec"});
                mem_phase(RD2, RFWE | PCWE, PCWE, dw, {name, "_ld"});
            end
            default: begin
                cyc(exec_rdy, WE2, {name, "_exec"});
                mem_phase(WE2, PCWE, PCWE, dw, {name, "_st"});
            end
        endcase
        if (retires && intr_v && mie_v)
            cyc(1'($urandom_range(0, 1)), INTT | PCWE, {name, "_intr"});
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t       tbl [14];
    logic [6:0] rops [12];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{7'b0010011, 3'b000, PCWE | RFWE, "addi"};
        tbl[1]  = '{7'b0110011, 3'b000, PCWE | RFWE, "add"};
        tbl[2]  = '{7'b0110111, 3'b101, PCWE | RFWE, "lui"};
        tbl[3]  = '{7'b0010111, 3'b011, PCWE | RFWE, "auipc"};
        tbl[4]  = '{7'b1101111, 3'b111, PCWE | RFWE, "jal"};
        tbl[5]  = '{7'b1100111, 3'b000, PCWE | RFWE, "jalr"};
        tbl[6]  = '{7'b1100011, 3'b001, PCWE, "branch"};
        tbl[7]  = '{7'b0000011, 3'b010, RD2, "lw"};
        tbl[8]  = '{7'b0100011, 3'b010, WE2, "sw"};
        tbl[9]  = '{7'b1110011, 3'b000, PCWE | MRT, "mret"};
        tbl[10] = '{7'b1110011, 3'b001, PCWE | RFWE | CSRW, "csrrw"};
        tbl[11] = '{7'b1110011, 3'b010, PCWE | ILL, "csrrs_ill"};
        tbl[12] = '{7'b1111111, 3'b000, PCWE | ILL, "op7f_ill"};
        tbl[13] = '{7'b0000000, 3'b000, PCWE | ILL, "op00_ill"};

        rops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                 7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011, 7'b1110011,
                 7'b1110011, 7'b1111111};

        // Reset: INIT drives only RESET_OUT, for exactly one cycle after release
        rst = 1'b1; intr = 1'b0; mie = 1'b0; opcode = ADDI; funct3 = 3'b000; mem_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs, RSTO);
        check("reset_buserr", {10'd0, bus_err}, 11'd0);
        rst = 1'b0;
        cyc(1'b1, RSTO, "init");

        // Decode table: FETCH, EXEC against table, then finish memory ops at once
        for (int i = 0; i < 14; i++) begin
            opcode = tbl[i].op; funct3 = tbl[i].f3; intr = 1'b1; mie = 1'b0;
            cyc(1'b1, RD1 | IRWE, {tbl[i].name, "_fetch"});
            cyc(1'($urandom_range(0, 1)), tbl[i].exp, {tbl[i].name, "_exec"});
            if (tbl[i].op == LOAD)  cyc(1'b1, RD2 | RFWE | PCWE, {tbl[i].name, "_done"});
            if (tbl[i].op == STORE) cyc(1'b1, WE2 | PCWE, {tbl[i].name, "_done"});
        end

        // Corner sequences
        do_instr(ADDI, 3'b000, 0, 0, 1'b0, 1'b0, 1'b1, "addi_seq");
        do_instr(LOAD, 3'b010, 0, 2, 1'b0, 1'b0, 1'b0, "lw_3low");
        do_instr(STORE, 3'b010, 0, 1, 1'b1, 1'b1, 1'b0, "sw_intr");
        do_instr(STORE, 3'b010, 0, 1, 1'b1, 1'b0, 1'b0, "sw_nomie");
        do_instr(SYS, 3'b000, 0, 0, 1'b1, 1'b1, 1'b0, "mret_intr");
        do_instr(ADDI, 3'b000, 0, 0, 1'b1, 1'b1, 1'b0, "after_mret");
        do_instr(7'b1111111, 3'b000, 0, 0, 1'b0, 1'b0, 1'b0, "illegal");
        do_instr(LOAD, 3'b010, 2, 14, 1'b0, 1'b0, 1'b0, "lw_rdy_at_limit");
        do_instr(ADDI, 3'b000, 20, 0, 1'b0, 1'b0, 1'b0, "fetch_timeout");
        do_instr(BRANCH, 3'b000, 0, 0, 1'b0, 1'b0, 1'b1, "after_timeout");

        // Asynchronous reset in the middle of a load wait
        opcode = LOAD; funct3 = 3'b010; intr = 1'b0; mie = 1'b0;
        cyc(1'b1, RD1 | IRWE, "rst_ld_fetch");
        cyc(1'b0, RD2, "rst_ld_exec");
        cyc(1'b0, RD2, "rst_ld_wait");
        mem_rdy = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_outs", outs, RSTO);
        check("rst_async_buserr", {10'd0, bus_err}, 11'd0);
        bus_flag = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, RSTO, "rst_init");

        do_instr(LOAD, 3'b010, 0, 30, 1'b1, 1'b1, 1'b0, "lw_timeout");
        do_instr(STORE, 3'b010, 0, 30, 1'b0, 1'b1, 1'b0, "sw_timeout");

        // Randomized instruction stream
        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            int fw, dw;
            op = rops[$urandom_range(0, 11)];
            f3 = 3'($urandom_range(0, 7));
            if (op == SYS && $urandom_range(0, 1) == 1) f3 = 3'($urandom_range(0, 1));
            fw = ($urandom_range(0, 24) == 0) ? 15 + int'($urandom_range(0, 5)) : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 12) == 0) ? 14 + int'($urandom_range(0, 4)) : int'($urandom_range(0, 4));
            do_instr(op, f3, fw, dw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
